// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
//   Shared types and constants for the data-memory responder.
//   - state_e        : responder FSM states (IDLE, BUSY, DONE)
//   - DMEM_POISON    : value returned on loads that fail (timeout/misaligned)
//   - dmem_cnt_w()   : width of the watchdog counter for a given TIMEOUT
//   - dmem_misaligned(): true when a byte address is not word aligned
// -----------------------------------------------------------------------------
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [31:0] DMEM_POISON = 32'hDEADBEEF;

  // Counter must be able to hold TIMEOUT itself.
  function automatic int dmem_cnt_w(input int timeout);
    return $clog2(timeout + 1);
  endfunction

  function automatic logic dmem_misaligned(input logic [1:0] addr_lsb);
    return (addr_lsb != 2'b00);
  endfunction

endpackage

// File: rtl/dmem_watchdog.sv
// -----------------------------------------------------------------------------
// dmem_watchdog
//   Counts cycles while enabled and pulses expired_o on the TIMEOUT-th enabled
//   cycle. The count returns to zero whenever clear_i is high.
//
//   Ports:
//     clk_i      in   clock, rising edge
//     rst_n_i    in   asynchronous active-low reset
//     clear_i    in   zero the counter (takes priority over enable_i)
//     enable_i   in   count this cycle
//     expired_o  out  combinational pulse: this is the TIMEOUT-th enabled cycle
// -----------------------------------------------------------------------------
module dmem_watchdog
  import dmem_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CNT_W = dmem_cnt_w(TIMEOUT);
  // The counter holds the number of enabled cycles already completed, so the
  // TIMEOUT-th enabled cycle is the one that sees TIMEOUT-1.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  if (TIMEOUT < 2) begin : g_timeout_check
    $error("dmem_watchdog: TIMEOUT must be at least 2");
  end

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && (cnt_q != CNT_LAST)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = enable_i && !clear_i && (cnt_q == CNT_LAST);

endmodule

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//   Memory-stage responder. Turns the EX/MEM MemRead/MemWrite/address/data
//   outputs into a multi-cycle req/ack data-memory transaction, stalls the
//   pipeline while the access is outstanding and returns load data to MEM/WB.
//   A watchdog forces completion of hung accesses and flags an error.
//
//   Optional feature (compile-time macro DMEM_WBUF_EN):
//     one-entry posted write buffer. An aligned write seen in IDLE is
//     accepted without stalling and drained to memory in the background;
//     any access arriving during the drain stalls until the drain's ack.
//
//   Ports:
//     clk_i        in   clock, rising edge
//     rst_n_i      in   asynchronous active-low reset
//     MemRead_i    in   load request from EX/MEM
//     MemWrite_i   in   store request from EX/MEM (wins over MemRead_i)
//     addr_i       in   byte address from EX/MEM
//     wdata_i      in   store data from EX/MEM
//     stall_o      out  hold the pipeline (combinational)
//     rdata_o      out  load data (registered)
//     rvalid_o     out  one-cycle pulse, rdata_o valid
//     err_o        out  sticky error: timeout or misaligned address
//     mem_req_o    out  memory request (registered)
//     mem_we_o     out  memory write enable
//     mem_addr_o   out  memory byte address (registered)
//     mem_wdata_o  out  memory write data (registered)
//     mem_ack_i    in   one-cycle completion strobe
//     mem_rdata_i  in   read data, valid with mem_ack_i
// -----------------------------------------------------------------------------
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       wdata_i,
  output logic              stall_o,
  output logic [31:0]       rdata_o,
  output logic              rvalid_o,
  output logic              err_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [31:0]       mem_rdata_i
);

  state_e              state_q,  state_d;
  logic                req_q,    req_d;
  logic                we_q,     we_d;
  logic [ADDR_W-1:0]   maddr_q,  maddr_d;
  logic [31:0]         mwdata_q, mwdata_d;
  logic [31:0]         rdata_q,  rdata_d;
  logic                rvalid_q, rvalid_d;
  logic                err_q,    err_d;
  // High while the BUSY state is draining a posted write rather than
  // servicing a blocking access; stays 0 when the buffer is not built.
  logic                drain_q,  drain_d;

  logic access;
  logic misaligned;
  logic post_write;
  logic wd_clear;
  logic wd_enable;
  logic wd_expired;

  assign access     = MemRead_i | MemWrite_i;
  assign misaligned = dmem_misaligned(addr_i[1:0]);

`ifdef DMEM_WBUF_EN
  // The buffer is empty whenever the FSM is idle: the drain is the only
  // thing that can occupy it and it always finishes back in IDLE.
  assign post_write = (state_q == ST_IDLE) && MemWrite_i && !misaligned;
`else
  assign post_write = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Watchdog: counts BUSY cycles, restarts every time BUSY is entered.
  // ---------------------------------------------------------------------------
  assign wd_enable = (state_q == ST_BUSY);
  assign wd_clear  = (state_q != ST_BUSY);

  dmem_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .clear_i   (wd_clear),
    .enable_i  (wd_enable),
    .expired_o (wd_expired)
  );

  // ---------------------------------------------------------------------------
  // Stall: raised the same cycle an access appears in IDLE, held through BUSY.
  // A background drain only stalls accesses that actually arrive. Gated by
  // reset so nothing is held while the pipeline is being reset.
  // ---------------------------------------------------------------------------
  always_comb begin
    stall_o = 1'b0;
    case (state_q)
      ST_IDLE: stall_o = access && !post_write;
      ST_BUSY: stall_o = drain_q ? access : 1'b1;
      default: stall_o = 1'b0;
    endcase
    stall_o = stall_o && rst_n_i;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    we_d     = we_q;
    maddr_d  = maddr_q;
    mwdata_d = mwdata_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    err_d    = err_q;
    drain_d  = drain_q;

    case (state_q)
      ST_IDLE: begin
        if (access) begin
          if (misaligned) begin
            // Never reaches the memory port; loads see poison data.
            err_d   = 1'b1;
            state_d = ST_DONE;
            if (!MemWrite_i) begin
              rdata_d  = DMEM_POISON;
              rvalid_d = 1'b1;
            end
          end else begin
            req_d    = 1'b1;
            we_d     = MemWrite_i;
            maddr_d  = addr_i[ADDR_W-1:0];
            mwdata_d = wdata_i;
            drain_d  = post_write;
            state_d  = ST_BUSY;
          end
        end
      end

      ST_BUSY: begin
        // Ack beats a simultaneous watchdog expiry.
        if (mem_ack_i) begin
          req_d   = 1'b0;
          drain_d = 1'b0;
          if (!we_q) begin
            rdata_d  = mem_rdata_i;
            rvalid_d = 1'b1;
          end
          // A drained posted write has no pipeline-visible completion.
          state_d = drain_q ? ST_IDLE : ST_DONE;
        end else if (wd_expired) begin
          req_d   = 1'b0;
          drain_d = 1'b0;
          err_d   = 1'b1;
          if (!drain_q) begin
            rdata_d = DMEM_POISON;
          end
          if (!we_q) begin
            rvalid_d = 1'b1;
          end
          state_d = drain_q ? ST_IDLE : ST_DONE;
        end
      end

      ST_DONE: begin
        // EX/MEM still shows the finished access this cycle; ignore it.
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
        drain_d = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= ST_IDLE;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      maddr_q  <= '0;
      mwdata_q <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      drain_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      we_q     <= we_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      drain_q  <= drain_d;
    end
  end

  assign rdata_o     = rdata_q;
  assign rvalid_o    = rvalid_q;
  assign err_o       = err_q;
  assign mem_req_o   = req_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = maddr_q;
  assign mem_wdata_o = mwdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
//   Directed self-checking bench for dmem_responder with TIMEOUT=8.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

  localparam int TIMEOUT = 8;
`ifdef DMEM_WBUF_EN
  localparam bit WBUF = 1'b1;
`else
  localparam bit WBUF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        stall;
  logic [31:0] rdata;
  logic        rvalid;
  logic        err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dmem_responder #(
    .ADDR_W  (32),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .MemRead_i   (MemRead),
    .MemWrite_i  (MemWrite),
    .addr_i      (addr),
    .wdata_i     (wdata),
    .stall_o     (stall),
    .rdata_o     (rdata),
    .rvalid_o    (rvalid),
    .err_o       (err),
    .mem_req_o   (mem_req),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_ack_i   (mem_ack),
    .mem_rdata_i (mem_rdata)
  );

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Presents one access (starting in IDLE, at posedge+2) and plays the memory:
  // ack on the ack_at-th request cycle (0 = never). Inputs are withdrawn the
  // cycle after stall_o is seen low, then one extra idle cycle is observed.
  task automatic run_access(input logic wr, input logic [31:0] a, input logic [31:0] d,
                            input int ack_at, input logic [31:0] ack_data,
                            output int st, output int rq, output int rises, output int rv,
                            output logic [31:0] rd_s, output logic we_s,
                            output logic [31:0] addr_s, output logic [31:0] wd_s,
                            output bit finished);
    bit consumed;
    logic prev;
    st = 0; rq = 0; rises = 0; rv = 0; rd_s = '0; we_s = 1'b0;
    addr_s = '0; wd_s = '0; finished = 0; consumed = 0; prev = 1'b0;
    MemRead = !wr; MemWrite = wr; addr = a; wdata = d;
    for (int c = 0; c < 100; c++) begin
      if (consumed) begin
        MemRead = 1'b0; MemWrite = 1'b0;
      end
      mem_ack = 1'b0;
      #1;
      if (stall) st++;
      if (mem_req && !prev) rises++;
      prev = mem_req;
      if (mem_req) begin
        rq++;
        we_s = mem_we; addr_s = mem_addr; wd_s = mem_wdata;
        if (rq == ack_at) begin
          mem_ack = 1'b1; mem_rdata = ack_data;
        end
      end
      if (rvalid) begin
        rv++; rd_s = rdata;
      end
      if (!stall) consumed = 1;
      if (consumed && !mem_req && c > 0) begin
        finished = 1;
        break;
      end
      step();
    end
    step();
    MemRead = 1'b0; MemWrite = 1'b0; mem_ack = 1'b0;
    #1;
    if (rvalid) rv++;
    if (mem_req && !prev) rises++;
    $display("access we=%0d addr=%h stall_cycles=%0d req_cycles=%0d req_rises=%0d rvalid=%0d rdata=%h err=%0d done=%0d",
             wr, a, st, rq, rises, rv, rd_s, err, finished);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    MemRead = 1'b1; addr = 32'h40;
    #12;
    n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", stall); end
    n_cmp++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", mem_req); end
    n_cmp++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got %b want 0", rvalid); end
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
    n_cmp++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", rdata); end
    n_cmp++; if ({mem_we, mem_addr, mem_wdata} !== 65'h0) begin n_fail++; $display("FAIL reset_memport: got we=%b a=%h d=%h want 0", mem_we, mem_addr, mem_wdata); end
    MemRead = 1'b0; addr = '0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_read();
    int st, rq, rises, rv; logic [31:0] rd, a, d; logic we; bit fin;
    run_access(1'b0, 32'h40, 32'h0, 3, 32'h12345678, st, rq, rises, rv, rd, we, a, d, fin);
    n_cmp++; if (fin !== 1'b1) begin n_fail++; $display("FAIL read_done: got %b want 1", fin); end
    n_cmp++; if (st != 4) begin n_fail++; $display("FAIL read_stall_cycles: got %0d want 4", st); end
    n_cmp++; if (rq != 3) begin n_fail++; $display("FAIL read_req_cycles: got %0d want 3", rq); end
    n_cmp++; if (rv != 1) begin n_fail++; $display("FAIL read_rvalid_pulses: got %0d want 1", rv); end
    n_cmp++; if (rd !== 32'h12345678) begin n_fail++; $display("FAIL read_rdata: got %h want 12345678", rd); end
    n_cmp++; if (a !== 32'h40 || we !== 1'b0) begin n_fail++; $display("FAIL read_memport: got a=%h we=%b want 40/0", a, we); end
    // Stray ack in IDLE must be ignored.
    mem_ack = 1'b1; mem_rdata = 32'h99999999;
    step();
    mem_ack = 1'b0;
    #1;
    n_cmp++; if (rvalid !== 1'b0 || rdata !== 32'h12345678 || mem_req !== 1'b0)
      begin n_fail++; $display("FAIL idle_ack_ignored: got rvalid=%b rdata=%h req=%b want 0/12345678/0", rvalid, rdata, mem_req); end
    step();
  endtask

  task automatic test_write();
    int st, rq, rises, rv; logic [31:0] rd, a, d; logic we; bit fin;
    run_access(1'b1, 32'h80, 32'hCAFEF00D, 1, 32'h0, st, rq, rises, rv, rd, we, a, d, fin);
    n_cmp++; if (fin !== 1'b1) begin n_fail++; $display("FAIL write_done: got %b want 1", fin); end
    n_cmp++; if (we !== 1'b1 || a !== 32'h80 || d !== 32'hCAFEF00D)
      begin n_fail++; $display("FAIL write_memport: got we=%b a=%h d=%h want 1/80/cafef00d", we, a, d); end
    n_cmp++; if (rv != 0) begin n_fail++; $display("FAIL write_rvalid: got %0d want 0", rv); end
    n_cmp++; if (rises != 1 || rq != 1) begin n_fail++; $display("FAIL write_one_request: got rises=%0d cycles=%0d want 1/1", rises, rq); end
    n_cmp++; if (st != (WBUF ? 0 : 2)) begin n_fail++; $display("FAIL write_stall_cycles: got %0d want %0d", st, WBUF ? 0 : 2); end
  endtask

  task automatic test_back_to_back();
    int st, rq, rises, rv; logic [31:0] rd, a, d; logic we; bit fin;
    run_access(1'b0, 32'h100, 32'h0, 1, 32'hA5A50001, st, rq, rises, rv, rd, we, a, d, fin);
    n_cmp++; if (st != 2 || rd !== 32'hA5A50001) begin n_fail++; $display("FAIL b2b_first: got stall=%0d rdata=%h want 2/a5a50001", st, rd); end
    run_access(1'b0, 32'h104, 32'h0, 1, 32'hA5A50002, st, rq, rises, rv, rd, we, a, d, fin);
    n_cmp++; if (st != 2 || rd !== 32'hA5A50002 || a !== 32'h104) begin n_fail++; $display("FAIL b2b_second: got stall=%0d rdata=%h a=%h want 2/a5a50002/104", st, rd, a); end
  endtask

  task automatic test_ack_at_timeout();
    int st, rq, rises, rv; logic [31:0] rd, a, d; logic we; bit fin;
    run_access(1'b0, 32'h200, 32'h0, TIMEOUT, 32'h0BADF00D, st, rq, rises, rv, rd, we, a, d, fin);
    n_cmp++; if (rd !== 32'h0BADF00D) begin n_fail++; $display("FAIL ack_vs_timeout_rdata: got %h want 0badf00d", rd); end
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL ack_vs_timeout_err: got %b want 0", err); end
    n_cmp++; if (rq != TIMEOUT) begin n_fail++; $display("FAIL ack_vs_timeout_req: got %0d want %0d", rq, TIMEOUT); end
  endtask

  task automatic test_misaligned();
    int st, rq, rises, rv; logic [31:0] rd, a, d; logic we; bit fin;
    run_access(1'b0, 32'h42, 32'h0, 1, 32'h11111111, st, rq, rises, rv, rd, we, a, d, fin);
    n_cmp++; if (rq != 0) begin n_fail++; $display("FAIL misalign_no_req: got %0d req cycles want 0", rq); end
    n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL misalign_err: got %b want 1", err); end
    n_cmp++; if (rd !== 32'hDEADBEEF || rv != 1) begin n_fail++; $display("FAIL misalign_rdata: got %h rvalid=%0d want deadbeef/1", rd, rv); end
    n_cmp++; if (st != 1) begin n_fail++; $display("FAIL misalign_stall: got %0d want 1", st); end
  endtask

  task automatic test_async_reset();
    int st, rq, rises, rv; logic [31:0] rd, a, d; logic we; bit fin;
    MemRead = 1'b1; addr = 32'h300;
    step();
    #1;
    n_cmp++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL areset_busy_req: got %b want 1", mem_req); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (mem_req !== 1'b0 || stall !== 1'b0) begin n_fail++; $display("FAIL areset_clear: got req=%b stall=%b want 0/0", mem_req, stall); end
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL areset_err: got %b want 0", err); end
    step();
    MemRead = 1'b0;
    rst_n = 1'b1;
    step();
    run_access(1'b0, 32'h304, 32'h0, 2, 32'h76543210, st, rq, rises, rv, rd, we, a, d, fin);
    n_cmp++; if (st != 3 || rd !== 32'h76543210 || rv != 1) begin n_fail++; $display("FAIL areset_next_read: got stall=%0d rdata=%h rvalid=%0d want 3/76543210/1", st, rd, rv); end
  endtask

  task automatic test_timeout();
    int st, rq, rises, rv; logic [31:0] rd, a, d; logic we; bit fin;
    run_access(1'b0, 32'h400, 32'h0, 0, 32'h0, st, rq, rises, rv, rd, we, a, d, fin);
    n_cmp++; if (fin !== 1'b1) begin n_fail++; $display("FAIL timeout_done: got %b want 1", fin); end
    n_cmp++; if (st != TIMEOUT + 1) begin n_fail++; $display("FAIL timeout_stall: got %0d want %0d", st, TIMEOUT + 1); end
    n_cmp++; if (rq != TIMEOUT) begin n_fail++; $display("FAIL timeout_req: got %0d want %0d", rq, TIMEOUT); end
    n_cmp++; if (rd !== 32'hDEADBEEF || rv != 1) begin n_fail++; $display("FAIL timeout_rdata: got %h rvalid=%0d want deadbeef/1", rd, rv); end
    n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL timeout_err: got %b want 1", err); end
    run_access(1'b0, 32'h404, 32'h0, 1, 32'h00C0FFEE, st, rq, rises, rv, rd, we, a, d, fin);
    n_cmp++; if (err !== 1'b1 || rd !== 32'h00C0FFEE) begin n_fail++; $display("FAIL err_sticky: got err=%b rdata=%h want 1/00c0ffee", err, rd); end
  endtask

`ifdef DMEM_WBUF_EN
  task automatic test_wbuf();
    MemWrite = 1'b1; addr = 32'h500; wdata = 32'h11112222;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL wbuf_post_stall: got %b want 0", stall); end
    step();
    MemWrite = 1'b0; MemRead = 1'b1; addr = 32'h504;
    #1;
    n_cmp++; if (stall !== 1'b1 || mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h500)
      begin n_fail++; $display("FAIL wbuf_drain: got stall=%b req=%b we=%b a=%h want 1/1/1/500", stall, mem_req, mem_we, mem_addr); end
    step();
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_fail++; $display("FAIL wbuf_read_held: got %b want 1", stall); end
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    #1;
    n_cmp++; if (stall !== 1'b1 || mem_req !== 1'b0) begin n_fail++; $display("FAIL wbuf_read_idle: got stall=%b req=%b want 1/0", stall, mem_req); end
    step();
    #1;
    n_cmp++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h504)
      begin n_fail++; $display("FAIL wbuf_read_issue: got req=%b we=%b a=%h want 1/0/504", mem_req, mem_we, mem_addr); end
    mem_ack = 1'b1; mem_rdata = 32'h55AA55AA;
    step();
    mem_ack = 1'b0;
    #1;
    n_cmp++; if (stall !== 1'b0 || rvalid !== 1'b1 || rdata !== 32'h55AA55AA)
      begin n_fail++; $display("FAIL wbuf_read_done: got stall=%b rvalid=%b rdata=%h want 0/1/55aa55aa", stall, rvalid, rdata); end
    $display("wbuf write 500 then read 504 rdata=%h", rdata);
    step();
    MemRead = 1'b0;
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_read();
    test_write();
    test_back_to_back();
    test_ack_at_timeout();
    test_misaligned();
    test_async_reset();
    test_timeout();
`ifdef DMEM_WBUF_EN
    test_wbuf();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
